s_type_store: RTL and testbench
===============================

// Module: s_type_store
// PURPOSE
//  - RISC-V RV32I store-path lane control: decodes an S-type instruction and the data address into per-byte write enables, lane-aligned write data and a misalignment flag.
//  - Sits between the execute-stage AGU and the data-memory write port; also exports the sign-extended S-immediate to the AGU.
//  - Outputs are registered, so results appear one clock after a valid input.
// PARAMETERS
//  - (none); data path fixed at XLEN=32, 4 byte lanes
// PORTS
//  clk        in   1   system clock, rising edge
//  rst_n      in   1   synchronous active-low reset
//  in_valid   in   1   instr/daddr/rs2_data qualify this cycle
//  instr      in   32  instruction word; funct3 = instr[14:12], opcode = instr[6:0]
//  daddr      in   32  effective data byte address; only daddr[1:0] used for lanes
//  rs2_data   in   32  store source register value
//  we_S       out  4   byte write enables, bit i -> byte lane i (bits 8i+7:8i)
//  wdata      out  32  rs2 data shifted into the addressed lanes
//  imm_s      out  32  sign-extended {instr[31:25], instr[11:7]} (combinational)
//  misalign   out  1   store address not naturally aligned for its size
//  illegal    out  1   funct3 not SB/SH/SW (or opcode mismatch, see CONFIGURATION)
//  out_valid  out  1   registered copy of in_valid
// BEHAVIOUR
//  - One clock domain, clk. Synchronous active-low reset: on a rising edge with rst_n=0, we_S=0, wdata=0, misalign=0, illegal=0, out_valid=0.
//  - Latency: one cycle. Inputs sampled at edge N appear on registered outputs after edge N.
//  - in_valid=0 at edge: out_valid<=0, we_S<=0, misalign<=0, illegal<=0; wdata holds its previous value.
//  - With off = daddr[1:0], decode funct3:
//    - 000 SB: we_S = 4'b0001 << off; wdata = {4{rs2[7:0]}}; never misaligned.
//    - 001 SH:
//      - off[0]=0: we_S = 4'b0011 << off; wdata = {2{rs2[15:0]}}.
//      - off[0]=1: we_S = 0; misalign = 1.
//    - 010 SW:
//      - off=0: we_S = 4'b1111; wdata = rs2.
//      - off!=0: we_S = 0; misalign = 1.
//    - 011..111: we_S = 0; illegal = 1; misalign = 0.
//  - wdata lane replication is unconditional for legal sizes, so data sits correctly at every offset; memory uses only the enabled lanes.
//  - misalign and illegal are never both 1. When either is 1, we_S = 0, so no partial write occurs.
//  - daddr[31:2] is ignored.
//  - imm_s is combinational from instr, independent of clk and reset: imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]}.
//  - Reset asserted while a store is in flight: reset wins at that edge and outputs clear. The store is dropped, not replayed.
//  - Back-to-back valid inputs: one result per cycle, no stalls, no backpressure.
// CONFIGURATION
//  - Macro S_TYPE_OPCODE_CHECK_EN:
//    - Defined: decode is qualified by opcode == 7'b0100011. Any other opcode gives we_S = 0, illegal = 1, misalign = 0.
//    - Undefined (default): opcode is ignored and decode uses funct3 only, so instr = 32'h0 is treated as SB.
// TESTING
//  - Reset: rst_n=0 for 2 edges -> we_S=0, wdata=0, misalign=0, illegal=0, out_valid=0.
//  - instr=32'h0000_0000, daddr=1, in_valid=1 (macro off) -> next edge: we_S=4'b0010 (2), misalign=0.
//  - instr=32'h0000_2000 (SW), daddr=1 -> we_S=0, misalign=1. Same instr with daddr=0 -> we_S=4'hF, wdata=rs2.
//  - instr=32'h0000_1000 (SH), daddr=2, rs2=32'h1234_ABCD -> we_S=4'b1100, wdata=32'hABCD_ABCD.
//  - instr=32'h0000_4000 (funct3=100), daddr=0 -> we_S=0, illegal=1.
//    - With S_TYPE_OPCODE_CHECK_EN defined, instr=32'h0000_0000 -> illegal=1.
//  - instr=32'hFE00_0FA3 -> imm_s=32'hFFFF_FFFF immediately.
//    - Pulse in_valid for one cycle -> out_valid high for exactly one cycle.

Source files
------------

// File: rtl/s_type_store_if.sv
// Store-lane bus between the AGU/execute stage and the s_type_store decoder.
// The master drives the instruction, address and store data; the slave returns lane controls.
interface s_type_store_if;
    logic        in_valid;
    logic [31:0] instr;
    logic [31:0] daddr;
    logic [31:0] rs2_data;
    logic [3:0]  we_S;
    logic [31:0] wdata;
    logic [31:0] imm_s;
    logic        misalign;
    logic        illegal;
    logic        out_valid;

    modport master (
        output in_valid, instr, daddr, rs2_data,
        input  we_S, wdata, imm_s, misalign, illegal, out_valid
    );

    modport slave (
        input  in_valid, instr, daddr, rs2_data,
        output we_S, wdata, imm_s, misalign, illegal, out_valid
    );
endinterface

// File: rtl/s_type_store.sv
// RV32I store-path lane control: byte enables, lane-replicated write data, misalign/illegal flags.
// Optional macro S_TYPE_OPCODE_CHECK_EN qualifies the decode with the STORE opcode.
module s_type_store (
    input  logic          clk,
    input  logic          rst_n,
    s_type_store_if.slave bus
);
    logic [2:0]  funct3;
    logic [1:0]  off;
    logic        decode_ok;
    logic [3:0]  we_next;
    logic [31:0] wdata_next;
    logic        misalign_next;
    logic        illegal_next;
    logic        unused_bits;

    assign funct3 = bus.instr[14:12];
    assign off    = bus.daddr[1:0];

`ifdef S_TYPE_OPCODE_CHECK_EN
    localparam logic [6:0] STORE_OPCODE = 7'b0100011;
    assign decode_ok   = (bus.instr[6:0] == STORE_OPCODE);
    assign unused_bits = ^{bus.daddr[31:2], bus.instr[24:15]};
`else
    assign decode_ok   = 1'b1;
    assign unused_bits = ^{bus.daddr[31:2], bus.instr[24:15], bus.instr[6:0]};
`endif

    assign bus.imm_s = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};

    // Data is replicated across all lanes for every legal size so that the enables alone select the bytes.
    always_comb begin
        we_next       = 4'b0000;
        wdata_next    = bus.rs2_data;
        misalign_next = 1'b0;
        illegal_next  = 1'b0;
        if (!decode_ok || funct3[2] || (funct3[1:0] == 2'b11)) begin
            illegal_next = 1'b1;
        end else begin
            case (funct3[1:0])
                2'b00: begin
                    we_next    = 4'b0001 << off;
                    wdata_next = {4{bus.rs2_data[7:0]}};
                end
                2'b01: begin
                    wdata_next = {2{bus.rs2_data[15:0]}};
                    if (off[0]) misalign_next = 1'b1;
                    else        we_next       = 4'b0011 << off;
                end
                default: begin
                    if (off != 2'b00) misalign_next = 1'b1;
                    else              we_next       = 4'b1111;
                end
            endcase
        end
    end

    // An idle cycle clears the controls but leaves wdata holding its last value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.we_S      <= 4'b0000;
            bus.wdata     <= 32'h0;
            bus.misalign  <= 1'b0;
            bus.illegal   <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.we_S     <= we_next;
                bus.wdata    <= wdata_next;
                bus.misalign <= misalign_next;
                bus.illegal  <= illegal_next;
            end else begin
                bus.we_S     <= 4'b0000;
                bus.misalign <= 1'b0;
                bus.illegal  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_s_type_store.sv
// Self-checking bench for s_type_store: directed spec cases then randomized stores against a lane-level model.
module tb_s_type_store;
    logic clk = 1'b0;
    logic rst_n;

    s_type_store_if bus ();

    s_type_store dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0]  exp_we;
    logic [31:0] exp_wdata;
    logic        exp_wdata_known;
    logic        exp_misalign;
    logic        exp_illegal;
    logic        exp_valid;

    task automatic compare_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model works from the access size in bytes and byte arithmetic on the address.
    task automatic model_store(input logic [31:0] ins, input logic [31:0] addr, input logic [31:0] rs2);
        int size;
        int offs;
        logic legal;
        legal = (ins[14:12] <= 3'd2);
`ifdef S_TYPE_OPCODE_CHECK_EN
        if (ins[6:0] != 7'h23) legal = 1'b0;
`endif
        exp_we       = 4'b0000;
        exp_misalign = 1'b0;
        exp_illegal  = 1'b0;
        if (!legal) begin
            exp_illegal     = 1'b1;
            exp_wdata_known = 1'b0;
        end else begin
            size = 1 << ins[14:12];
            offs = addr % 4;
            if ((offs % size) != 0) begin
                exp_misalign    = 1'b1;
                exp_wdata_known = 1'b0;
            end else begin
                for (int b = 0; b < size; b++) exp_we[offs + b] = 1'b1;
                for (int lane = 0; lane < 4; lane++)
                    exp_wdata[8*lane +: 8] = rs2[8*(lane % size) +: 8];
                exp_wdata_known = 1'b1;
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        compare_value({tag, ".out_valid"}, {31'b0, bus.out_valid}, {31'b0, exp_valid});
        compare_value({tag, ".we_S"},      {28'b0, bus.we_S},      {28'b0, exp_we});
        compare_value({tag, ".misalign"},  {31'b0, bus.misalign},  {31'b0, exp_misalign});
        compare_value({tag, ".illegal"},   {31'b0, bus.illegal},   {31'b0, exp_illegal});
        if (exp_wdata_known) compare_value({tag, ".wdata"}, bus.wdata, exp_wdata);
    endtask

    task automatic applyStimulus(input string tag, input logic rst, input logic v,
                                 input logic [31:0] ins, input logic [31:0] addr, input logic [31:0] rs2);
        logic signed [11:0] field;
        @(negedge clk);
        rst_n        = rst;
        bus.in_valid = v;
        bus.instr    = ins;
        bus.daddr    = addr;
        bus.rs2_data = rs2;
        #1;
        field = {ins[31:25], ins[11:7]};
        compare_value({tag, ".imm_s"}, bus.imm_s, int'(field));
        if (!rst) begin
            exp_valid = 1'b0; exp_we = 4'b0; exp_misalign = 1'b0; exp_illegal = 1'b0;
            exp_wdata = 32'h0; exp_wdata_known = 1'b1;
        end else if (!v) begin
            exp_valid = 1'b0; exp_we = 4'b0; exp_misalign = 1'b0; exp_illegal = 1'b0;
        end else begin
            exp_valid = 1'b1;
            model_store(ins, addr, rs2);
        end
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        logic [31:0] ins;
        logic        v;
        logic        r;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.instr = 32'h0;
        bus.daddr = 32'h0;
        bus.rs2_data = 32'h0;
        exp_wdata = 32'h0;
        exp_wdata_known = 1'b1;

        applyStimulus("reset0", 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        applyStimulus("reset1", 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);

        applyStimulus("sb_off1",   1'b1, 1'b1, 32'h0000_0000, 32'h1, 32'hDEAD_BEEF);
        applyStimulus("sw_mis",    1'b1, 1'b1, 32'h0000_2000, 32'h1, 32'h1122_3344);
        applyStimulus("sw_ok",     1'b1, 1'b1, 32'h0000_2000, 32'h0, 32'h1122_3344);
        applyStimulus("sh_off2",   1'b1, 1'b1, 32'h0000_1000, 32'h2, 32'h1234_ABCD);
        applyStimulus("idle_hold", 1'b1, 1'b0, 32'h0000_1000, 32'h2, 32'h5555_5555);
        applyStimulus("sh_mis",    1'b1, 1'b1, 32'h0000_1023, 32'h3, 32'h1234_ABCD);
        applyStimulus("f3_100",    1'b1, 1'b1, 32'h0000_4000, 32'h0, 32'h0);
        applyStimulus("f3_111",    1'b1, 1'b1, 32'h0000_70A3, 32'h0, 32'h0);
        applyStimulus("imm_neg1",  1'b1, 1'b1, 32'hFE00_0FA3, 32'hFFFF_FFF3, 32'hCAFE_F00D);
        applyStimulus("pulse_end", 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
        applyStimulus("rst_drop",  1'b0, 1'b1, 32'h0000_2023, 32'h0, 32'hFFFF_FFFF);
        applyStimulus("b2b_0",     1'b1, 1'b1, 32'h0000_0023, 32'h3, 32'hA5A5_0077);
        applyStimulus("b2b_1",     1'b1, 1'b1, 32'h0000_1023, 32'h0, 32'h0000_BEEF);

        for (int i = 0; i < 400; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 1) == 1) ins[6:0] = 7'h23;
            if ($urandom_range(0, 3) != 0) ins[14:12] = 3'($urandom_range(0, 2));
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 29) != 0);
            applyStimulus("rand", r, v, ins, $urandom, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
